// File: rtl/sdram_x16_model_if.sv
`default_nettype none
// ============================================================================
// Module  : sdram_x16_model_if
// Brief   : Command, address and byte-mask pins between an SDR SDRAM
//           controller and the sdram_x16_model memory model.
// Revision: 1.0  initial release
// ============================================================================
interface sdram_x16_model_if;
  logic        Cke;
  logic        Cs_n;
  logic        Ras_n;
  logic        Cas_n;
  logic        We_n;
  logic [1:0]  Ba;
  logic [12:0] Addr;
  logic [1:0]  Dqm;

  // Controller side drives the pins
  modport master (output Cke, Cs_n, Ras_n, Cas_n, We_n, Ba, Addr, Dqm);
  // Memory model samples the pins
  modport slave  (input  Cke, Cs_n, Ras_n, Cas_n, We_n, Ba, Addr, Dqm);
endinterface
`default_nettype wire

// File: rtl/sdram_x16_model.sv
`default_nettype none
// ============================================================================
// Module  : sdram_x16_model
// Brief   : Cycle-accurate 16-bit SDR SDRAM model, 4 banks, per-bank open
//           row tracking, burst read/write with CAS latency 2/3, byte masks
//           and a sticky protocol-error flag.
// Revision: 1.0  initial release
// ============================================================================
module sdram_x16_model #(
  parameter int ROW_BITS = 13,
  parameter int COL_BITS = 9
) (
  input  wire              Clk,
  input  wire              rst,
  sdram_x16_model_if.slave bus,
  inout  wire [15:0]       Dq,
  output logic             err
);

  localparam int c_addr_w = 2 + ROW_BITS + COL_BITS;

  typedef enum logic [1:0] {
    B_IDLE  = 2'd0,
    B_READ  = 2'd1,
    B_WRITE = 2'd2
  } burst_st_t;

  // Backing store: {bank, row, column}; never cleared by reset
  logic [15:0] mem [0:(2**c_addr_w)-1];

  logic [11:0]         mode_q, mode_d;
  logic [3:0]          bank_open_q, bank_open_d;
  logic [ROW_BITS-1:0] bank_row_q [4];
  logic [ROW_BITS-1:0] bank_row_d [4];

  // Burst engine: k_q is the word index acted on at the next edge
  burst_st_t           st_q, st_d;
  logic [1:0]          bbank_q, bbank_d;
  logic [COL_BITS-1:0] start_q, start_d;
  logic [COL_BITS-1:0] k_q, k_d;
  logic [COL_BITS-1:0] bmask_q, bmask_d;
  logic                full_q, full_d;
  logic                intlv_q, intlv_d;
  logic                ap_q, ap_d;

  // Read data pipeline (s1 is the extra stage used at CL=3)
  logic                s1_vld_q, s1_vld_d;
  logic [15:0]         s1_dat_q, s1_dat_d;
  logic                out_vld_q, out_vld_d;
  logic [15:0]         out_dat_q, out_dat_d;
  logic [1:0]          out_msk_q, out_msk_d;
  logic [1:0]          dqm1_q, dqm1_d;
  logic                err_q, err_d;

  logic [3:0]          w_cmd;
  logic                w_is_act, w_is_rd, w_is_wr, w_is_bst;
  logic                w_is_pre, w_is_ref, w_is_lmr;
  logic                w_rd_ok, w_wr_ok, w_pre_hit, w_intr, w_rd_push;
  logic                w_busy, w_any_open, w_last, w_cl3;
  logic [COL_BITS-1:0] w_mode_mask;
  logic                w_mode_full;
  logic [COL_BITS-1:0] w_bcol;
  logic [c_addr_w-1:0] w_baddr, w_caddr, w_mem_addr;
  logic [15:0]         w_rd_word;
  logic                w_mem_we;
  logic [1:0]          w_dq_oe;
  logic                unused_w;

  assign unused_w = bus.Addr[12];

  assign w_cmd    = {bus.Cs_n, bus.Ras_n, bus.Cas_n, bus.We_n};
  assign w_is_act = (w_cmd == 4'b0011);
  assign w_is_rd  = (w_cmd == 4'b0101);
  assign w_is_wr  = (w_cmd == 4'b0100);
  assign w_is_bst = (w_cmd == 4'b0110);
  assign w_is_pre = (w_cmd == 4'b0010);
  assign w_is_ref = (w_cmd == 4'b0001);
  assign w_is_lmr = (w_cmd == 4'b0000);

  assign w_busy     = (st_q != B_IDLE);
  assign w_any_open = |bank_open_q;
  assign w_cl3      = (mode_q[6:4] == 3'd3);
  assign w_rd_ok    = bus.Cke & w_is_rd & bank_open_q[bus.Ba];
  assign w_wr_ok    = bus.Cke & w_is_wr & bank_open_q[bus.Ba];
  assign w_pre_hit  = bus.Cke & w_is_pre & (bus.Addr[10] | (bus.Ba == bbank_q));
  assign w_intr     = w_busy & (w_rd_ok | w_wr_ok | (bus.Cke & w_is_bst) | w_pre_hit);
  // A WRITE takes the bus, so the word of an interrupted read is dropped
  assign w_rd_push  = bus.Cke & (st_q == B_READ) & ~w_wr_ok;
  assign w_last     = ~full_q & (k_q == bmask_q);

  // Burst length of the current mode as a column wrap mask; reserved -> 1
  always_comb begin
    w_mode_mask = '0;
    w_mode_full = 1'b0;
    case (mode_q[2:0])
      3'b001:  w_mode_mask = COL_BITS'(1);
      3'b010:  w_mode_mask = COL_BITS'(3);
      3'b011:  w_mode_mask = COL_BITS'(7);
      3'b111: begin
        w_mode_mask = '1;
        w_mode_full = 1'b1;
      end
      default: w_mode_mask = '0;
    endcase
  end

  // Column of the burst word: offset wraps inside the aligned block
  assign w_bcol = intlv_q ? ((start_q & ~bmask_q) | ((start_q ^ k_q) & bmask_q))
                          : ((start_q & ~bmask_q) | ((start_q + k_q) & bmask_q));

  assign w_baddr   = {bbank_q, bank_row_q[bbank_q], w_bcol};
  assign w_caddr   = {bus.Ba, bank_row_q[bus.Ba], bus.Addr[COL_BITS-1:0]};
  assign w_rd_word = mem[w_baddr];

  // Next-state logic: pipeline, burst engine and command decode
  always_comb begin
    mode_d      = mode_q;
    bank_open_d = bank_open_q;
    bank_row_d  = bank_row_q;
    st_d        = st_q;
    bbank_d     = bbank_q;
    start_d     = start_q;
    k_d         = k_q;
    bmask_d     = bmask_q;
    full_d      = full_q;
    intlv_d     = intlv_q;
    ap_d        = ap_q;
    s1_vld_d    = s1_vld_q;
    s1_dat_d    = s1_dat_q;
    out_vld_d   = out_vld_q;
    out_dat_d   = out_dat_q;
    out_msk_d   = out_msk_q;
    dqm1_d      = dqm1_q;
    err_d       = err_q;
    w_mem_we    = 1'b0;
    w_mem_addr  = w_baddr;

    // Cke low freezes everything (clock suspend)
    if (bus.Cke) begin
      dqm1_d    = bus.Dqm;
      out_msk_d = dqm1_q;
      s1_vld_d  = w_rd_push;
      s1_dat_d  = w_rd_word;
      if (w_wr_ok) begin
        out_vld_d = 1'b0;
      end else if (w_cl3) begin
        out_vld_d = s1_vld_q;
        out_dat_d = s1_dat_q;
      end else begin
        out_vld_d = w_rd_push;
        out_dat_d = w_rd_word;
      end

      // Step the active burst; an interrupted auto-precharge burst keeps its row open
      if (w_busy) begin
        if ((st_q == B_WRITE) && !w_intr) begin
          w_mem_we = 1'b1;
        end
        if (w_intr) begin
          st_d = B_IDLE;
        end else if (w_last) begin
          st_d = B_IDLE;
          if (ap_q) begin
            bank_open_d[bbank_q] = 1'b0;
          end
        end else begin
          k_d = k_q + COL_BITS'(1);
        end
      end

      if (w_is_act) begin
        if (bank_open_q[bus.Ba]) begin
          err_d = 1'b1;
        end else begin
          bank_open_d[bus.Ba] = 1'b1;
          bank_row_d[bus.Ba]  = bus.Addr[ROW_BITS-1:0];
        end
      end

      if (w_is_rd || w_is_wr) begin
        if (!bank_open_q[bus.Ba]) begin
          err_d = 1'b1;
        end else begin
          bbank_d = bus.Ba;
          start_d = bus.Addr[COL_BITS-1:0];
          bmask_d = w_mode_mask;
          full_d  = w_mode_full;
          intlv_d = mode_q[3] & ~w_mode_full;
          ap_d    = bus.Addr[10] & ~w_mode_full;
          if (w_is_rd) begin
            st_d = B_READ;
            k_d  = '0;
          end else begin
            // Word 0 is captured on the WRITE edge itself
            w_mem_we   = 1'b1;
            w_mem_addr = w_caddr;
            k_d        = COL_BITS'(1);
            if (mode_q[9] || ((w_mode_mask == '0) && !w_mode_full)) begin
              st_d = B_IDLE;
              if (bus.Addr[10]) begin
                bank_open_d[bus.Ba] = 1'b0;
              end
            end else begin
              st_d = B_WRITE;
            end
          end
        end
      end

      if (w_is_pre) begin
        if (bus.Addr[10]) begin
          bank_open_d = '0;
        end else begin
          bank_open_d[bus.Ba] = 1'b0;
        end
      end

      if (w_is_ref && w_any_open) begin
        err_d = 1'b1;
      end

      // Reserved CL rejects the load; reserved BL loads and behaves as BL=1
      if (w_is_lmr) begin
        if (w_any_open) begin
          err_d = 1'b1;
        end else if ((bus.Addr[6:4] != 3'd2) && (bus.Addr[6:4] != 3'd3)) begin
          err_d = 1'b1;
        end else begin
          mode_d = bus.Addr[11:0];
          if ((bus.Addr[2:0] > 3'd3) && (bus.Addr[2:0] != 3'd7)) begin
            err_d = 1'b1;
          end
        end
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (rst) begin
      mode_q      <= 12'h020;
      bank_open_q <= '0;
      bank_row_q  <= '{default: '0};
      st_q        <= B_IDLE;
      bbank_q     <= '0;
      start_q     <= '0;
      k_q         <= '0;
      bmask_q     <= '0;
      full_q      <= 1'b0;
      intlv_q     <= 1'b0;
      ap_q        <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_dat_q    <= '0;
      out_vld_q   <= 1'b0;
      out_dat_q   <= '0;
      out_msk_q   <= '0;
      dqm1_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      bank_open_q <= bank_open_d;
      bank_row_q  <= bank_row_d;
      st_q        <= st_d;
      bbank_q     <= bbank_d;
      start_q     <= start_d;
      k_q         <= k_d;
      bmask_q     <= bmask_d;
      full_q      <= full_d;
      intlv_q     <= intlv_d;
      ap_q        <= ap_d;
      s1_vld_q    <= s1_vld_d;
      s1_dat_q    <= s1_dat_d;
      out_vld_q   <= out_vld_d;
      out_dat_q   <= out_dat_d;
      out_msk_q   <= out_msk_d;
      dqm1_q      <= dqm1_d;
      err_q       <= err_d;
    end
  end

  // Byte-masked write into the array
  always_ff @(posedge Clk) begin
    if (!rst && w_mem_we) begin
      if (!bus.Dqm[0]) mem[w_mem_addr][7:0]  <= Dq[7:0];
      if (!bus.Dqm[1]) mem[w_mem_addr][15:8] <= Dq[15:8];
    end
  end

  // Masked byte lanes float during read data
  assign w_dq_oe = {2{out_vld_q}} & ~out_msk_q;

  for (genvar b = 0; b < 2; b++) begin : g_dq
    assign Dq[b*8 +: 8] = w_dq_oe[b] ? out_dat_q[b*8 +: 8] : 8'hzz;
  end

  assign err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_x16_model.sv
`default_nettype none
// ============================================================================
// Module  : tb_sdram_x16_model
// Brief   : Directed self-checking bench for sdram_x16_model.
// Revision: 1.0  initial release
// ============================================================================
module tb_sdram_x16_model;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_BST = 4'b0110;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_LMR = 4'b0000;
  localparam logic [31:0] BUS_Z = 32'h0;

  logic        Clk = 1'b0;
  logic        rst;
  logic        err;
  logic        tb_oe;
  logic [15:0] tb_dq;
  wire  [15:0] dq;
  logic [1:0]  dut_oe;
  int          n_tests = 0;
  int          n_fail  = 0;

  sdram_x16_model_if bus ();

  assign dq = tb_oe ? tb_dq : 16'hzzzz;

  sdram_x16_model #(.ROW_BITS(4), .COL_BITS(9)) u_dut (
    .Clk (Clk),
    .rst (rst),
    .bus (bus),
    .Dq  (dq),
    .err (err)
  );

  assign dut_oe = u_dut.w_dq_oe;

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // {lane enables, data of enabled lanes}; all zero means fully high-Z
  function automatic logic [31:0] bus_obs();
    return {14'b0, dut_oe, dq & {{8{dut_oe[1]}}, {8{dut_oe[0]}}}};
  endfunction

  function automatic logic [31:0] word(input logic [15:0] x);
    return {16'h0003, x};
  endfunction

  task automatic issue(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                       input logic de, input logic [15:0] d, input logic [1:0] m);
    @(negedge Clk);
    {bus.Cs_n, bus.Ras_n, bus.Cas_n, bus.We_n} = c;
    bus.Ba   = ba;
    bus.Addr = a;
    bus.Dqm  = m;
    tb_oe    = de;
    tb_dq    = d;
    @(posedge Clk);
    #1;
    {bus.Cs_n, bus.Ras_n, bus.Cas_n, bus.We_n} = C_NOP;
    bus.Ba   = 2'd0;
    bus.Addr = 13'd0;
    bus.Dqm  = 2'd0;
    tb_oe    = 1'b0;
  endtask

  task automatic cmd(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a);
    issue(c, ba, a, 1'b0, 16'h0, 2'b00);
  endtask

  task automatic nop();
    cmd(C_NOP, 2'd0, 13'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    nop();
    nop();
    rst = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: sequence did not complete, expected finish before 50000");
    $fatal(1);
  end

  initial begin
    logic [15:0] ea [4];
    rst      = 1'b1;
    bus.Cke  = 1'b1;
    {bus.Cs_n, bus.Ras_n, bus.Cas_n, bus.We_n} = C_NOP;
    bus.Ba   = 2'd0;
    bus.Addr = 13'd0;
    bus.Dqm  = 2'd0;
    tb_oe    = 1'b0;
    tb_dq    = 16'h0;
    do_reset();
    check("rst_err", 32'(err), 32'd0);
    check("rst_dq", bus_obs(), BUS_Z);

    // CL2 BL4 write burst then read burst
    cmd(C_LMR, 2'd0, 13'h022);
    cmd(C_ACT, 2'd1, 13'd5);
    issue(C_WR,  2'd1, 13'd8, 1'b1, 16'h1111, 2'b00);
    issue(C_NOP, 2'd0, 13'd0, 1'b1, 16'h2222, 2'b00);
    issue(C_NOP, 2'd0, 13'd0, 1'b1, 16'h3333, 2'b00);
    issue(C_NOP, 2'd0, 13'd0, 1'b1, 16'h4444, 2'b00);
    nop();
    cmd(C_RD, 2'd1, 13'd8);
    check("a_rd_edge_z", bus_obs(), BUS_Z);
    ea = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int i = 0; i < 4; i++) begin
      nop();
      check($sformatf("a_rd_w%0d", i), bus_obs(), word(ea[i]));
    end
    nop();
    check("a_rd_end_z", bus_obs(), BUS_Z);
    check("a_err", 32'(err), 32'd0);

    // CL3 BL4 read at column 10: sequential wrap 10,11,8,9
    cmd(C_PRE, 2'd0, 13'h400);
    cmd(C_LMR, 2'd0, 13'h032);
    cmd(C_ACT, 2'd1, 13'd5);
    cmd(C_RD, 2'd1, 13'd10);
    check("b_lat0_z", bus_obs(), BUS_Z);
    nop();
    check("b_lat1_z", bus_obs(), BUS_Z);
    ea = '{16'h3333, 16'h4444, 16'h1111, 16'h2222};
    for (int i = 0; i < 4; i++) begin
      nop();
      check($sformatf("b_rd_w%0d", i), bus_obs(), word(ea[i]));
    end
    nop();
    check("b_rd_end_z", bus_obs(), BUS_Z);

    // BL1: byte-masked write and byte-masked read
    cmd(C_PRE, 2'd0, 13'h400);
    cmd(C_LMR, 2'd0, 13'h020);
    cmd(C_ACT, 2'd1, 13'd5);
    issue(C_WR, 2'd1, 13'd20,  1'b1, 16'h1234, 2'b00);
    issue(C_WR, 2'd1, 13'd20,  1'b1, 16'hABCD, 2'b10);
    issue(C_WR, 2'd1, 13'd510, 1'b1, 16'h5155, 2'b00);
    issue(C_WR, 2'd1, 13'd511, 1'b1, 16'h5110, 2'b00);
    issue(C_WR, 2'd1, 13'd0,   1'b1, 16'hA000, 2'b00);
    issue(C_WR, 2'd1, 13'd1,   1'b1, 16'hA001, 2'b00);
    cmd(C_RD, 2'd1, 13'd20);
    nop();
    check("c_dqm_wr", bus_obs(), word(16'h12CD));
    nop();
    check("c_bl1_end_z", bus_obs(), BUS_Z);
    issue(C_RD, 2'd1, 13'd510, 1'b0, 16'h0, 2'b10);
    nop();
    check("c_dqm_rd", bus_obs(), {14'b0, 2'b01, 16'h0055});

    // Full page read from 510 terminated three edges later
    cmd(C_PRE, 2'd0, 13'h400);
    cmd(C_LMR, 2'd0, 13'h027);
    cmd(C_ACT, 2'd1, 13'd5);
    cmd(C_RD, 2'd1, 13'd510);
    nop();
    check("d_fp_w0", bus_obs(), word(16'h5155));
    nop();
    check("d_fp_w1", bus_obs(), word(16'h5110));
    cmd(C_BST, 2'd0, 13'd0);
    check("d_fp_w2", bus_obs(), word(16'hA000));
    nop();
    check("d_bst_z0", bus_obs(), BUS_Z);
    nop();
    check("d_bst_z1", bus_obs(), BUS_Z);

    // Clock suspend for two edges in the middle of a CL2 BL4 read
    cmd(C_PRE, 2'd0, 13'h400);
    cmd(C_LMR, 2'd0, 13'h022);
    cmd(C_ACT, 2'd1, 13'd5);
    cmd(C_RD, 2'd1, 13'd8);
    nop();
    check("e_w0", bus_obs(), word(16'h1111));
    bus.Cke = 1'b0;
    nop();
    check("e_hold1", bus_obs(), word(16'h1111));
    nop();
    check("e_hold2", bus_obs(), word(16'h1111));
    bus.Cke = 1'b1;
    ea = '{16'h2222, 16'h3333, 16'h4444, 16'h0000};
    for (int i = 0; i < 3; i++) begin
      nop();
      check($sformatf("e_w%0d", i + 1), bus_obs(), word(ea[i]));
    end
    nop();
    check("e_end_z", bus_obs(), BUS_Z);
    check("e_err", 32'(err), 32'd0);

    // Protocol errors are sticky until reset
    cmd(C_RD, 2'd2, 13'd0);
    check("f_rd_idle_err", 32'(err), 32'd1);
    nop();
    nop();
    nop();
    check("f_err_sticky", 32'(err), 32'd1);
    do_reset();
    check("f_rst_clr", 32'(err), 32'd0);
    cmd(C_ACT, 2'd0, 13'd1);
    check("f_act_ok", 32'(err), 32'd0);
    cmd(C_ACT, 2'd0, 13'd2);
    check("f_act_twice", 32'(err), 32'd1);
    do_reset();
    cmd(C_ACT, 2'd3, 13'd0);
    cmd(C_REF, 2'd0, 13'd0);
    check("f_ref_open", 32'(err), 32'd1);
    do_reset();
    cmd(C_LMR, 2'd0, 13'h040);
    check("f_lmr_cl4", 32'(err), 32'd1);

    // Reset restores CL2 BL1; memory contents survive reset
    do_reset();
    cmd(C_ACT, 2'd1, 13'd5);
    cmd(C_RD, 2'd1, 13'd8);
    check("g_rd_edge_z", bus_obs(), BUS_Z);
    nop();
    check("g_rd_w0", bus_obs(), word(16'h1111));
    nop();
    check("g_bl1_z", bus_obs(), BUS_Z);
    check("g_err", 32'(err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
